// File: rtl/fnd_pkg.sv
// fnd_pkg: shared segment constants, hex decode table and counter-width helper
package fnd_pkg;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  function automatic int cnt_w(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fnd_seg7.sv
// fnd_seg7: combinational hex to active-low {a..g} segment decoder
module fnd_seg7
  import fnd_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = SEG_TAB[hex];
endmodule

// File: rtl/fnd_disp_ctrl.sv
// fnd_disp_ctrl: registered multi-digit 7-segment controller with blank/blink masks.
// Define FND_SCAN_EN to build the time-multiplexed scan bus (seg_out/dig_sel).
module fnd_disp_ctrl
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int SCAN_DIV   = 50_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  output logic [7*NUM_DIGITS-1:0] fnd_on,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel
);
  localparam int BW = cnt_w(BLINK_DIV);
  logic [4*NUM_DIGITS-1:0] dig_q;
  logic [NUM_DIGITS-1:0]   blank_q, blink_q;
  logic [BW-1:0]           blink_cnt;
  logic                    blink_ph, blink_wrap;
  logic [7*NUM_DIGITS-1:0] pat;
  assign blink_wrap = blink_cnt == BW'(BLINK_DIV - 1);
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    logic [6:0] dec;
    fnd_seg7 u_seg (.hex(dig_q[4*i +: 4]), .seg(dec));
    assign pat[7*i +: 7] = (blank_q[i] | (blink_q[i] & blink_ph)) ? SEG_BLANK : dec;
  end
  // blank_q resets to all ones so the display stays dark until the first load
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dig_q     <= '0;
      blank_q   <= '1;
      blink_q   <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      fnd_on    <= '1;
    end else begin
      if (load) begin
        dig_q   <= digits_in;
        blank_q <= blank_in;
        blink_q <= blink_in;
      end
      blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
      blink_ph  <= blink_ph ^ blink_wrap;
      fnd_on    <= pat;
    end
`ifdef FND_SCAN_EN
  localparam int SW = cnt_w(SCAN_DIV);
  localparam int IW = cnt_w(NUM_DIGITS);
  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] scan_idx;
  logic          scan_wrap;
  assign scan_wrap = scan_cnt == SW'(SCAN_DIV - 1);
  // segments and select update on the same edge, so no ghosting between digits
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      seg_out  <= SEG_BLANK;
      dig_sel  <= '1;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      if (scan_wrap) scan_idx <= scan_idx == IW'(NUM_DIGITS - 1) ? '0 : scan_idx + 1'b1;
      seg_out  <= fnd_on[7*scan_idx +: 7];
      dig_sel  <= ~(NUM_DIGITS'(1) << scan_idx);
    end
`else
  assign seg_out = SEG_BLANK;
  assign dig_sel = '1;
`endif
endmodule

// File: tb/tb_fnd_disp_ctrl.sv
// tb_fnd_disp_ctrl: table-driven check of the parallel path, blink, scan bus and async reset
module tb_fnd_disp_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  blank_in = '0, blink_in = '0;
  logic [27:0] fnd_on;
  logic [6:0]  seg_out;
  logic [3:0]  dig_sel;
  int total = 0, bad = 0, edge_n = 0;
  logic [27:0] exp_prev = '1;
  logic [6:0]  seg_ref [17];

  fnd_disp_ctrl #(.NUM_DIGITS(4), .BLINK_DIV(4), .SCAN_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in),
    .blank_in(blank_in), .blink_in(blink_in),
    .fnd_on(fnd_on), .seg_out(seg_out), .dig_sel(dig_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [15:0] dig;
    logic [3:0]  blk;
    logic [3:0]  bln;
    logic [27:0] exp;
  } vec_t;
  vec_t tab [29];

  function automatic logic [27:0] fx(input int a, input int b, input int c, input int d);
    return {seg_ref[a], seg_ref[b], seg_ref[c], seg_ref[d]};
  endfunction

  task automatic cmp(input string name, input logic [27:0] act, input logic [27:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] bk,
                      input logic [3:0] bn, input logic [27:0] exp);
    int idx;
    load = ld; digits_in = d; blank_in = bk; blink_in = bn;
    @(posedge clk); #1;
    edge_n++;
    cmp($sformatf("fnd_on e%0d", edge_n), fnd_on, exp);
`ifdef FND_SCAN_EN
    idx = ((edge_n - 1) / 2) % 4;
    cmp($sformatf("seg_out e%0d", edge_n), {21'h0, seg_out}, {21'h0, exp_prev[idx*7 +: 7]});
    cmp($sformatf("dig_sel e%0d", edge_n), {24'h0, dig_sel}, {24'h0, ~(4'b0001 << idx)});
`else
    cmp($sformatf("seg_out e%0d", edge_n), {21'h0, seg_out}, 28'h7F);
    cmp($sformatf("dig_sel e%0d", edge_n), {24'h0, dig_sel}, 28'hF);
`endif
    exp_prev = exp;
  endtask

  initial begin
    logic [27:0] dk, n1208, d1208;
    seg_ref = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000, 7'b1111111};
    dk    = fx(16, 16, 16, 16);
    n1208 = fx(1, 2, 0, 8);
    d1208 = fx(1, 2, 0, 16);
    // entry k is applied before edge 21+k; blink phase is 1 after edges 4..7, 12..15, ...
    tab = '{
      '{1, 16'h1208, 4'h0, 4'h0, dk},
      '{0, 16'hFFFF, 4'hF, 4'hF, n1208},
      '{1, 16'h1208, 4'h0, 4'h1, n1208},
      '{0, 16'hFFFF, 4'hF, 4'hF, d1208},
      '{0, 16'hFFFF, 4'hF, 4'hF, n1208},
      '{0, 16'hFFFF, 4'hF, 4'hF, n1208},
      '{0, 16'hFFFF, 4'hF, 4'hF, n1208},
      '{0, 16'hFFFF, 4'hF, 4'hF, n1208},
      '{0, 16'hFFFF, 4'hF, 4'hF, d1208},
      '{0, 16'hFFFF, 4'hF, 4'hF, d1208},
      '{0, 16'hFFFF, 4'hF, 4'hF, d1208},
      '{0, 16'hFFFF, 4'hF, 4'hF, d1208},
      '{0, 16'hFFFF, 4'hF, 4'hF, n1208},
      '{0, 16'hFFFF, 4'hF, 4'hF, n1208},
      '{0, 16'hFFFF, 4'hF, 4'hF, n1208},
      '{1, 16'h4567, 4'h0, 4'h2, n1208},
      '{0, 16'hFFFF, 4'hF, 4'hF, fx(4, 5, 16, 7)},
      '{1, 16'h4567, 4'h0, 4'h0, fx(4, 5, 16, 7)},
      '{0, 16'hFFFF, 4'hF, 4'hF, fx(4, 5, 6, 7)},
      '{1, 16'h4567, 4'h8, 4'h0, fx(4, 5, 6, 7)},
      '{0, 16'hFFFF, 4'hF, 4'hF, fx(16, 5, 6, 7)},
      '{1, 16'h89AB, 4'h0, 4'h0, fx(16, 5, 6, 7)},
      '{1, 16'hCDEF, 4'h0, 4'h0, fx(8, 9, 10, 11)},
      '{1, 16'h3333, 4'h0, 4'hF, fx(12, 13, 14, 15)},
      '{0, 16'hFFFF, 4'hF, 4'h0, dk},
      '{0, 16'hFFFF, 4'hF, 4'h0, dk},
      '{0, 16'hFFFF, 4'hF, 4'h0, dk},
      '{0, 16'hFFFF, 4'hF, 4'h0, dk},
      '{0, 16'hFFFF, 4'hF, 4'h0, fx(3, 3, 3, 3)}
    };
    #12;
    cmp("rst fnd_on", fnd_on, 28'hFFFFFFF);
    cmp("rst seg_out", {21'h0, seg_out}, 28'h7F);
    cmp("rst dig_sel", {24'h0, dig_sel}, 28'hF);
    #10 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 4'h0, 4'h0, dk);
    for (int i = 0; i < 29; i++) step(tab[i].ld, tab[i].dig, tab[i].blk, tab[i].bln, tab[i].exp);
    #2 rst_n = 1'b0;
    #1;
    cmp("async fnd_on", fnd_on, 28'hFFFFFFF);
    cmp("async seg_out", {21'h0, seg_out}, 28'h7F);
    cmp("async dig_sel", {24'h0, dig_sel}, 28'hF);
    #3 rst_n = 1'b1;
    edge_n = 0;
    exp_prev = '1;
    step(1'b1, 16'h1208, 4'h0, 4'h1, dk);
    step(1'b0, 16'hFFFF, 4'hF, 4'hF, n1208);
    step(1'b0, 16'hFFFF, 4'hF, 4'hF, n1208);
    step(1'b0, 16'hFFFF, 4'hF, 4'hF, n1208);
    step(1'b0, 16'hFFFF, 4'hF, 4'hF, d1208);
    step(1'b0, 16'hFFFF, 4'hF, 4'hF, d1208);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
